// File: rtl/vga_pkg.sv
// Shared types and timing arithmetic for the streaming VGA timing generator.
package vga_pkg;

  localparam int unsigned DEFAULT_CW = 8;

  typedef struct packed {
    logic [DEFAULT_CW-1:0] r;
    logic [DEFAULT_CW-1:0] g;
    logic [DEFAULT_CW-1:0] b;
  } rgb_t;

  typedef enum logic {
    SYNC_WAIT = 1'b0,
    RUN       = 1'b1
  } state_t;

  function automatic int unsigned axis_total(input int unsigned active, input int unsigned fp,
                                             input int unsigned sync, input int unsigned bp);
    return active + fp + sync + bp;
  endfunction

  function automatic int unsigned sync_start(input int unsigned active, input int unsigned fp);
    return active + fp;
  endfunction

  function automatic int unsigned sync_end(input int unsigned active, input int unsigned fp,
                                           input int unsigned sync);
    return active + fp + sync;
  endfunction

endpackage

// File: rtl/vga_hv_counter.sv
// Horizontal/vertical raster counters with active-region and sync-window decode.
module vga_hv_counter
  import vga_pkg::*;
#(
  parameter int unsigned H_ACTIVE = 640,
  parameter int unsigned H_FP     = 16,
  parameter int unsigned H_SYNC   = 96,
  parameter int unsigned H_BP     = 48,
  parameter int unsigned V_ACTIVE = 480,
  parameter int unsigned V_FP     = 10,
  parameter int unsigned V_SYNC   = 2,
  parameter int unsigned V_BP     = 33,
  localparam int unsigned H_TOTAL = axis_total(H_ACTIVE, H_FP, H_SYNC, H_BP),
  localparam int unsigned V_TOTAL = axis_total(V_ACTIVE, V_FP, V_SYNC, V_BP),
  localparam int unsigned HW      = (H_TOTAL > 1) ? $clog2(H_TOTAL) : 1,
  localparam int unsigned VW      = (V_TOTAL > 1) ? $clog2(V_TOTAL) : 1
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          enable,
  output logic [HW-1:0] h,
  output logic [VW-1:0] v,
  output logic          active,
  output logic          hs_on,
  output logic          vs_on,
  output logic          origin,
  output logic          frame_end
);

  localparam int unsigned H_SS = sync_start(H_ACTIVE, H_FP);
  localparam int unsigned H_SE = sync_end(H_ACTIVE, H_FP, H_SYNC);
  localparam int unsigned V_SS = sync_start(V_ACTIVE, V_FP);
  localparam int unsigned V_SE = sync_end(V_ACTIVE, V_FP, V_SYNC);

  logic h_last;
  logic v_last;

  assign h_last = (h == HW'(H_TOTAL - 1));
  assign v_last = (v == VW'(V_TOTAL - 1));

  always_ff @(posedge clk) begin
    if (reset || !enable) begin
      h <= '0;
      v <= '0;
    end else if (h_last) begin
      h <= '0;
      v <= v_last ? '0 : v + VW'(1);
    end else begin
      h <= h + HW'(1);
    end
  end

  always_comb begin
    active    = (32'(h) < H_ACTIVE) && (32'(v) < V_ACTIVE);
    hs_on     = (32'(h) >= H_SS) && (32'(h) < H_SE);
    vs_on     = (32'(v) >= V_SS) && (32'(v) < V_SE);
    origin    = (h == '0) && (v == '0);
    frame_end = h_last && v_last;
  end

endmodule

// File: rtl/vga_stream_timing_gen.sv
// VGA timing generator fed by a valid/ready pixel stream aligned on start-of-frame,
// with sticky underflow/SOF error flags and automatic resync on the next frame.
module vga_stream_timing_gen
  import vga_pkg::*;
#(
  parameter int unsigned H_ACTIVE = 640,
  parameter int unsigned H_FP     = 16,
  parameter int unsigned H_SYNC   = 96,
  parameter int unsigned H_BP     = 48,
  parameter int unsigned V_ACTIVE = 480,
  parameter int unsigned V_FP     = 10,
  parameter int unsigned V_SYNC   = 2,
  parameter int unsigned V_BP     = 33,
  parameter bit          HS_POL   = 1'b0,
  parameter bit          VS_POL   = 1'b0,
  parameter int unsigned CW       = 8,
  localparam int unsigned H_TOTAL = axis_total(H_ACTIVE, H_FP, H_SYNC, H_BP),
  localparam int unsigned V_TOTAL = axis_total(V_ACTIVE, V_FP, V_SYNC, V_BP),
  localparam int unsigned XW      = (H_TOTAL > 1) ? $clog2(H_TOTAL) : 1,
  localparam int unsigned YW      = (V_TOTAL > 1) ? $clog2(V_TOTAL) : 1
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          enable,
  input  logic          clr_err,
  input  logic [3*CW-1:0] pix_data,
  input  logic          pix_valid,
  input  logic          pix_sof,
  output logic          pix_ready,
  output logic          vga_hs,
  output logic          vga_vs,
  output logic          vga_blank_n,
  output logic [3*CW-1:0] vga_rgb,
  output logic [XW-1:0] x,
  output logic [YW-1:0] y,
  output logic          frame_start,
  output logic          underflow,
  output logic          sof_err
);

  logic [XW-1:0] h;
  logic [YW-1:0] v;
  logic          active;
  logic          hs_on;
  logic          vs_on;
  logic          origin;
  logic          frame_end;

  state_t state;
  state_t state_next;
  logic   consume;
  logic   uf_evt;
  logic   sof_evt;

  vga_hv_counter #(
    .H_ACTIVE (H_ACTIVE),
    .H_FP     (H_FP),
    .H_SYNC   (H_SYNC),
    .H_BP     (H_BP),
    .V_ACTIVE (V_ACTIVE),
    .V_FP     (V_FP),
    .V_SYNC   (V_SYNC),
    .V_BP     (V_BP)
  ) u_hv (
    .clk       (clk),
    .reset     (reset),
    .enable    (enable),
    .h         (h),
    .v         (v),
    .active    (active),
    .hs_on     (hs_on),
    .vs_on     (vs_on),
    .origin    (origin),
    .frame_end (frame_end)
  );

  always_ff @(posedge clk) begin
    if (reset || !enable) begin
      state <= SYNC_WAIT;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      SYNC_WAIT: if (frame_end && pix_valid && pix_sof) state_next = RUN;
      RUN:       if (uf_evt || sof_evt) state_next = SYNC_WAIT;
      default:   state_next = SYNC_WAIT;
    endcase
  end

  // While waiting for sync, non-SOF pixels are drained and the SOF pixel is held
  // at the head so it can be consumed at (0,0) of the next frame.
  always_comb begin
    pix_ready = 1'b0;
    consume   = 1'b0;
    uf_evt    = 1'b0;
    sof_evt   = 1'b0;
    if (enable && !reset) begin
      case (state)
        SYNC_WAIT: pix_ready = pix_valid && !pix_sof;
        RUN: begin
          if (active) begin
            if (!pix_valid)              uf_evt  = 1'b1;
            else if (pix_sof != origin)  sof_evt = 1'b1;
            else                         consume = 1'b1;
            pix_ready = !sof_evt;
          end
        end
        default: pix_ready = 1'b0;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      vga_hs      <= !HS_POL;
      vga_vs      <= !VS_POL;
      vga_blank_n <= 1'b0;
      vga_rgb     <= '0;
      x           <= '0;
      y           <= '0;
      frame_start <= 1'b0;
      underflow   <= 1'b0;
      sof_err     <= 1'b0;
    end else begin
      underflow <= (underflow && !clr_err) || uf_evt;
      sof_err   <= (sof_err && !clr_err) || sof_evt;
      if (!enable) begin
        vga_hs      <= !HS_POL;
        vga_vs      <= !VS_POL;
        vga_blank_n <= 1'b0;
        vga_rgb     <= '0;
        x           <= '0;
        y           <= '0;
        frame_start <= 1'b0;
      end else begin
        vga_hs      <= hs_on ? HS_POL : !HS_POL;
        vga_vs      <= vs_on ? VS_POL : !VS_POL;
        vga_blank_n <= active;
        vga_rgb     <= consume ? pix_data : '0;
        x           <= h;
        y           <= v;
        frame_start <= origin;
      end
    end
  end

endmodule

// File: tb/tb_vga_stream_timing_gen.sv
// Bench for vga_stream_timing_gen: random pixel stream, a frame-arithmetic reference
// model, and directed fault steps (underflow, misplaced SOF, reset, enable drop).
module tb_vga_stream_timing_gen;
  import vga_pkg::*;

  localparam int unsigned HA = 8, HF = 2, HSW = 3, HB = 1;
  localparam int unsigned VA = 4, VF = 1, VSW = 2, VB = 1;
  localparam int unsigned CW = 8;
  localparam int unsigned HT = HA + HF + HSW + HB;
  localparam int unsigned VT = VA + VF + VSW + VB;
  localparam int unsigned FT = HT * VT;
  localparam int unsigned NPIX = HA * VA;
  localparam int unsigned XW = $clog2(HT);
  localparam int unsigned YW = $clog2(VT);

  typedef struct packed {
    logic            sof;
    logic [3*CW-1:0] data;
  } pix_t;

  logic clk = 1'b0;
  logic reset, enable, clr_err, pix_valid, pix_sof;
  logic [3*CW-1:0] pix_data;
  logic pix_ready, vga_hs, vga_vs, vga_blank_n, frame_start, underflow, sof_err;
  logic [3*CW-1:0] vga_rgb;
  logic [XW-1:0] x;
  logic [YW-1:0] y;
  logic p_ready, p_hs, p_vs, p_blank_n, p_fs, p_uf, p_se;
  logic [3*CW-1:0] p_rgb;
  logic [XW-1:0] p_x;
  logic [YW-1:0] p_y;

  always #5 clk = ~clk;

  vga_stream_timing_gen #(
    .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HSW), .H_BP(HB),
    .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VSW), .V_BP(VB),
    .HS_POL(1'b0), .VS_POL(1'b0), .CW(CW)
  ) dut (
    .clk(clk), .reset(reset), .enable(enable), .clr_err(clr_err),
    .pix_data(pix_data), .pix_valid(pix_valid), .pix_sof(pix_sof), .pix_ready(pix_ready),
    .vga_hs(vga_hs), .vga_vs(vga_vs), .vga_blank_n(vga_blank_n), .vga_rgb(vga_rgb),
    .x(x), .y(y), .frame_start(frame_start), .underflow(underflow), .sof_err(sof_err)
  );

  vga_stream_timing_gen #(
    .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HSW), .H_BP(HB),
    .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VSW), .V_BP(VB),
    .HS_POL(1'b1), .VS_POL(1'b1), .CW(CW)
  ) dut_pos (
    .clk(clk), .reset(reset), .enable(enable), .clr_err(clr_err),
    .pix_data(pix_data), .pix_valid(pix_valid), .pix_sof(pix_sof), .pix_ready(p_ready),
    .vga_hs(p_hs), .vga_vs(p_vs), .vga_blank_n(p_blank_n), .vga_rgb(p_rgb),
    .x(p_x), .y(p_y), .frame_start(p_fs), .underflow(p_uf), .sof_err(p_se)
  );

  int   checks = 0;
  int   failures = 0;
  pix_t src_q[$];
  int   next_bad = -1;
  bit   drop = 1'b0;
  // Reference model: position within the frame, lock to the stream, sticky flags.
  int unsigned t = 0;
  bit   locked = 1'b0;
  bit   m_uf = 1'b0;
  bit   m_se = 1'b0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic push_frame(input int bad_idx);
    for (int i = 0; i < int'(NPIX); i++) begin
      pix_t p;
      rgb_t c;
      c = rgb_t'(24'($urandom));
      p.sof  = (i == 0) || (i == bad_idx);
      p.data = c;
      src_q.push_back(p);
    end
  endtask

  task automatic step();
    pix_t head;
    bit vld, act, org, hs_a, vs_a, rdy, take, uf_e, se_e, run_now, e_uf, e_se;
    int unsigned hh, vv;
    logic [3*CW-1:0] e_rgb;
    while (src_q.size() < NPIX) begin
      push_frame(next_bad);
      next_bad = -1;
    end
    head = src_q[0];
    vld = !drop;
    pix_valid = vld;
    pix_data  = head.data;
    pix_sof   = head.sof;

    hh   = t % HT;
    vv   = t / HT;
    act  = (hh < HA) && (vv < VA);
    org  = (t == 0);
    hs_a = (hh >= HA + HF) && (hh < HA + HF + HSW);
    vs_a = (vv >= VA + VF) && (vv < VA + VF + VSW);
    run_now = enable && !reset;

    if (!run_now)     rdy = 1'b0;
    else if (!locked) rdy = vld && !head.sof;
    else              rdy = act && !(vld && (head.sof != org));
    uf_e = run_now && locked && act && !vld;
    se_e = run_now && locked && act && vld && (head.sof != org);
    take = run_now && locked && act && vld && (head.sof == org);
    e_rgb = take ? head.data : '0;
    e_uf = reset ? 1'b0 : ((m_uf && !clr_err) || uf_e);
    e_se = reset ? 1'b0 : ((m_se && !clr_err) || se_e);

    #5;
    chk("pix_ready", 32'(pix_ready), 32'(rdy));
    @(posedge clk);
    #1;
    if (!run_now) begin
      chk("hs_idle", 32'(vga_hs), 32'(1));
      chk("vs_idle", 32'(vga_vs), 32'(1));
      chk("hs_pos_idle", 32'(p_hs), 32'(0));
      chk("vs_pos_idle", 32'(p_vs), 32'(0));
      chk("blank_idle", 32'(vga_blank_n), 32'(0));
      chk("rgb_idle", 32'(vga_rgb), 32'(0));
      chk("xy_idle", 32'({x, y}), 32'(0));
      chk("fs_idle", 32'(frame_start), 32'(0));
    end else begin
      chk("hs", 32'(vga_hs), 32'(!hs_a));
      chk("vs", 32'(vga_vs), 32'(!vs_a));
      chk("hs_pos", 32'(p_hs), 32'(hs_a));
      chk("vs_pos", 32'(p_vs), 32'(vs_a));
      chk("blank_n", 32'(vga_blank_n), 32'(act));
      chk("rgb", 32'(vga_rgb), 32'(e_rgb));
      chk("x", 32'(x), hh);
      chk("y", 32'(y), vv);
      chk("frame_start", 32'(frame_start), 32'(org));
    end
    chk("underflow", 32'(underflow), 32'(e_uf));
    chk("sof_err", 32'(sof_err), 32'(e_se));

    if (rdy && vld) void'(src_q.pop_front());
    m_uf = e_uf;
    m_se = e_se;
    if (!run_now) begin
      t = 0;
      locked = 1'b0;
    end else begin
      if (!locked) locked = (t == FT - 1) && vld && head.sof;
      else if (uf_e || se_e) locked = 1'b0;
      t = (t + 1) % FT;
    end
  endtask

  task automatic run(input int unsigned n);
    for (int unsigned i = 0; i < n; i++) step();
  endtask

  task automatic run_to(input int unsigned pos);
    for (int unsigned i = 0; i <= FT && t != pos; i++) step();
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1; enable = 1'b1; clr_err = 1'b0;
    pix_valid = 1'b0; pix_sof = 1'b0; pix_data = '0;
    @(posedge clk);
    #1;
    run(3);
    reset = 1'b0;

    // Frame 0 waits for SOF, frame 1 streams.
    run(2 * FT);

    // Underflow at (3,1) of frame 2, then recovery and clear.
    run_to(1 * HT + 3);
    drop = 1'b1;
    step();
    drop = 1'b0;
    chk("underflow_set", 32'(underflow), 32'(1));
    run_to(0);
    run(FT);
    clr_err = 1'b1;
    step();
    clr_err = 1'b0;
    chk("underflow_clr", 32'(underflow), 32'(0));

    // Misplaced SOF at (5,0) of a later frame.
    run_to(0);
    next_bad = 5;
    run(4 * FT);
    chk("sof_err_set", 32'(sof_err), 32'(1));
    clr_err = 1'b1;
    step();
    clr_err = 1'b0;

    // Reset mid-frame at h=6, v=2.
    run_to(2 * HT + 6);
    reset = 1'b1;
    step();
    reset = 1'b0;
    run(3 * FT);

    // Enable held low for 50 cycles mid-frame.
    run_to(1 * HT + 5);
    enable = 1'b0;
    run(50);
    enable = 1'b1;
    step();
    chk("fs_after_enable", 32'(frame_start), 32'(1));
    run(3 * FT);

    // Random phase: sporadic drops, misplaced SOFs and clears.
    for (int unsigned i = 0; i < 8 * FT; i++) begin
      drop    = ($urandom_range(0, 149) == 0);
      clr_err = ($urandom_range(0, 59) == 0);
      if (next_bad < 0 && $urandom_range(0, 199) == 0) next_bad = int'($urandom_range(1, NPIX - 1));
      step();
    end
    drop = 1'b0;
    clr_err = 1'b0;
    run(3 * FT);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
